// File: rtl/sorting_engine.sv
// Fully pipelined 16-lane sorter: odd-even transposition network of 16 registered
// compare-exchange stages. One vector enters per clock; it leaves sorted 16 clocks later.
module sorting_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic [WIDTH-1:0] x5,
  input  logic [WIDTH-1:0] x6,
  input  logic [WIDTH-1:0] x7,
  input  logic [WIDTH-1:0] x8,
  input  logic [WIDTH-1:0] x9,
  input  logic [WIDTH-1:0] x10,
  input  logic [WIDTH-1:0] x11,
  input  logic [WIDTH-1:0] x12,
  input  logic [WIDTH-1:0] x13,
  input  logic [WIDTH-1:0] x14,
  input  logic [WIDTH-1:0] x15,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] s3,
  output logic [WIDTH-1:0] s4,
  output logic [WIDTH-1:0] s5,
  output logic [WIDTH-1:0] s6,
  output logic [WIDTH-1:0] s7,
  output logic [WIDTH-1:0] s8,
  output logic [WIDTH-1:0] s9,
  output logic [WIDTH-1:0] s10,
  output logic [WIDTH-1:0] s11,
  output logic [WIDTH-1:0] s12,
  output logic [WIDTH-1:0] s13,
  output logic [WIDTH-1:0] s14,
  output logic [WIDTH-1:0] s15
);

  logic [WIDTH-1:0] inVec   [16];
  logic [WIDTH-1:0] stage_q [16][16];
  logic [WIDTH-1:0] stage_d [16][16];

  assign inVec = '{x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15};

  // Stage k pairs lanes (0,1),(2,3).. when k is even and (1,2),(3,4).. when odd;
  // in odd stages lanes 0 and 15 have no partner and pass straight through.
  for (genvar k = 0; k < 16; k++) begin : g_stage
    logic [WIDTH-1:0] src [16];

    if (k == 0) begin : g_first
      assign src = inVec;
    end else begin : g_rest
      assign src = stage_q[k-1];
    end

    for (genvar l = 0; l < 16; l++) begin : g_lane
      if ((k % 2 == 0) && (l % 2 == 0)) begin : g_evenLo
        assign stage_d[k][l] = (src[l+1] < src[l]) ? src[l+1] : src[l];
      end else if (k % 2 == 0) begin : g_evenHi
        assign stage_d[k][l] = (src[l] < src[l-1]) ? src[l-1] : src[l];
      end else if ((l == 0) || (l == 15)) begin : g_oddPass
        assign stage_d[k][l] = src[l];
      end else if (l % 2 == 1) begin : g_oddLo
        assign stage_d[k][l] = (src[l+1] < src[l]) ? src[l+1] : src[l];
      end else begin : g_oddHi
        assign stage_d[k][l] = (src[l] < src[l-1]) ? src[l-1] : src[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        for (int l = 0; l < 16; l++) begin
          stage_q[k][l] <= '0;
        end
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign s0  = stage_q[15][0];
  assign s1  = stage_q[15][1];
  assign s2  = stage_q[15][2];
  assign s3  = stage_q[15][3];
  assign s4  = stage_q[15][4];
  assign s5  = stage_q[15][5];
  assign s6  = stage_q[15][6];
  assign s7  = stage_q[15][7];
  assign s8  = stage_q[15][8];
  assign s9  = stage_q[15][9];
  assign s10 = stage_q[15][10];
  assign s11 = stage_q[15][11];
  assign s12 = stage_q[15][12];
  assign s13 = stage_q[15][13];
  assign s14 = stage_q[15][14];
  assign s15 = stage_q[15][15];

endmodule

// File: tb/tb_sorting_engine.sv
// Self-checking bench for sorting_engine: a scoreboard queue holds the expected
// output for every edge, flushed to zeros whenever reset is applied.
module tb_sorting_engine;

  localparam int W = 16;
  typedef logic [16*W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] xv [16];
  wire  [W-1:0] sv [16];

  vec_t  expQ[$];
  string tagQ[$];
  int    totalChecks = 0;
  int    badChecks   = 0;

  sorting_engine #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]),
    .x4(xv[4]), .x5(xv[5]), .x6(xv[6]), .x7(xv[7]),
    .x8(xv[8]), .x9(xv[9]), .x10(xv[10]), .x11(xv[11]),
    .x12(xv[12]), .x13(xv[13]), .x14(xv[14]), .x15(xv[15]),
    .s0(sv[0]), .s1(sv[1]), .s2(sv[2]), .s3(sv[3]),
    .s4(sv[4]), .s5(sv[5]), .s6(sv[6]), .s7(sv[7]),
    .s8(sv[8]), .s9(sv[9]), .s10(sv[10]), .s11(sv[11]),
    .s12(sv[12]), .s13(sv[13]), .s14(sv[14]), .s15(sv[15])
  );

  always #5 clk = ~clk;

  // Reference sort: plain insertion sort on unsigned keys, lane 0 in the low bits.
  function automatic vec_t sortRef(input vec_t v);
    logic [W-1:0] a [16];
    logic [W-1:0] t;
    vec_t r;
    for (int i = 0; i < 16; i++) a[i] = v[i*W +: W];
    for (int i = 1; i < 16; i++) begin
      t = a[i];
      for (int j = i; j > 0; j--) begin
        if (a[j-1] > t) begin
          a[j] = a[j-1];
          a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 16; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  function automatic vec_t packArr(input logic [W-1:0] a [16]);
    vec_t r;
    for (int i = 0; i < 16; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  function automatic vec_t randVec(input bit narrow);
    vec_t r;
    for (int i = 0; i < 16; i++)
      r[i*W +: W] = narrow ? W'($urandom_range(0, 7)) : W'($urandom);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input vec_t observed, input vec_t expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, observed, expected);
    end
  endtask

  // Drives one vector across one edge. A reset edge zeroes every stage, so the
  // scoreboard is replaced by zeros; otherwise the expectation joins the tail.
  task automatic applyStimulus(input string tag, input vec_t vin, input vec_t vexp, input bit rst);
    vec_t  observed;
    vec_t  e;
    string t;
    for (int i = 0; i < 16; i++) xv[i] = vin[i*W +: W];
    reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      expQ.delete();
      tagQ.delete();
      repeat (16) begin
        expQ.push_back('0);
        tagQ.push_back("zero_after_reset");
      end
    end else begin
      expQ.push_back(vexp);
      tagQ.push_back(tag);
    end
    e = expQ.pop_front();
    t = tagQ.pop_front();
    for (int i = 0; i < 16; i++) observed[i*W +: W] = sv[i];
    checkOutput(t, observed, e);
  endtask

  initial begin
    vec_t         revVec, rampVec, b2bVec, dupVec, dupExp, eqVec, zeroVec, v;
    logic [W-1:0] dupIn  [16] = '{16'hFFFF, 16'h0000, 16'h0007, 16'h0007, 16'h8000, 16'h0001,
                                  16'hFFFF, 16'h0003, 16'h0003, 16'h0000, 16'h7FFF, 16'h0002,
                                  16'h0009, 16'h0009, 16'h8001, 16'h0005};
    logic [W-1:0] dupOut [16] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0003,
                                  16'h0005, 16'h0007, 16'h0007, 16'h0009, 16'h0009, 16'h7FFF,
                                  16'h8000, 16'h8001, 16'hFFFF, 16'hFFFF};

    for (int i = 0; i < 16; i++) begin
      revVec[i*W +: W]  = W'(15 - i);
      rampVec[i*W +: W] = W'(i);
      b2bVec[i*W +: W]  = W'((i * 5) % 16);
      eqVec[i*W +: W]   = 16'h1234;
    end
    zeroVec = '0;
    dupVec  = packArr(dupIn);
    dupExp  = packArr(dupOut);

    // Reset with garbage on the inputs, then idle on zeros.
    applyStimulus("reset0", randVec(1'b0), zeroVec, 1'b1);
    applyStimulus("reset1", randVec(1'b0), zeroVec, 1'b1);
    repeat (4) applyStimulus("idle_zero", zeroVec, zeroVec, 1'b0);

    // Single reverse vector followed by zeros: outputs stay zero until it emerges.
    applyStimulus("reset2", zeroVec, zeroVec, 1'b1);
    applyStimulus("reverse", revVec, rampVec, 1'b0);
    repeat (15) applyStimulus("zero_fill", zeroVec, zeroVec, 1'b0);

    applyStimulus("dups_extremes", dupVec, dupExp, 1'b0);
    applyStimulus("already_sorted", rampVec, rampVec, 1'b0);
    applyStimulus("all_equal", eqVec, eqVec, 1'b0);

    // Back-to-back A then B, then a dense random stream.
    applyStimulus("b2b_A", revVec, rampVec, 1'b0);
    applyStimulus("b2b_B", b2bVec, rampVec, 1'b0);
    for (int c = 0; c < 200; c++) begin
      v = randVec(c[0]);
      applyStimulus("random", v, sortRef(v), 1'b0);
    end

    // Mid-stream reset: everything in flight is discarded.
    for (int c = 0; c < 8; c++) begin
      v = randVec(1'b0);
      applyStimulus("pre_reset", v, sortRef(v), 1'b0);
    end
    applyStimulus("mid_reset", randVec(1'b0), zeroVec, 1'b1);
    for (int c = 0; c < 24; c++) begin
      v = randVec(c[0]);
      applyStimulus("post_reset", v, sortRef(v), 1'b0);
    end
    repeat (16) applyStimulus("drain", zeroVec, zeroVec, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
